// File: rtl/adc_spi_capture.sv
// Serial capture for an AD7476-class ADC: one CS_n/SCLK read frame per sample_tick,
// SCLK generated by clock-enable counting on clk, sample delivered with a valid pulse.
module adc_spi_capture #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int LEAD_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 adc_sdata,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] sample_out,
  output logic                 sample_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 overrun
);

  // state | meaning
  // IDLE  | waiting for sample_tick; CS_n and SCLK high
  // SETUP | CS_n low, SCLK held high for one half-period
  // SHIFT | FRAME_BITS SCLK periods, sdata captured on each rising edge
  // DONE  | CS_n high, sample_out/frame_err loaded, sample_valid pulse
  // QUIET | CS_n high, busy held for CLK_DIV-1 cycles before IDLE
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(CLK_DIV - 2);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    cs_n_q, cs_n_d;
  logic                    sclk_q, sclk_d;
  logic [DATA_BITS-1:0]    sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    if (sample_tick && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = '0;
        end
      end
      SETUP: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            // ADC data has been stable for a full low half-period here
            sclk_d  = 1'b1;
            shift_d = {shift_q[FRAME_BITS-2:0], adc_sdata};
          end else if (bit_q == BIT_LAST) begin
            state_d  = DONE;
            cs_n_d   = 1'b1;
            valid_d  = 1'b1;
            sample_d = shift_q[DATA_BITS-1:0];
            ferr_d   = |shift_q[FRAME_BITS-1 -: LEAD_BITS];
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + BW'(1);
          end
        end
      end
      DONE: begin
        state_d = QUIET;
        cnt_d   = '0;
      end
      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = ferr_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: behavioural ADC models drive two instances (CLK_DIV 4 and 2);
// frame timing, SCLK shape and captured words are checked against values derived from the frame rules.
module tb_adc_spi_capture;

  localparam int FB    = 16;
  localparam int DIV_A = 4;
  localparam int DIV_B = 2;
  localparam int LAT_A = DIV_A * (1 + 2 * FB) + 1;   // tick edge to valid
  localparam int LAT_B = DIV_B * (1 + 2 * FB) + 1;
  localparam int SPAN_A = LAT_A + DIV_A;             // tick edge to busy low

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic tick_a = 1'b0, sdata_a = 1'b0;
  logic cs_n_a, sclk_a, valid_a, ferr_a, busy_a, ovr_a;
  logic [11:0] out_a;
  logic tick_b = 1'b0, sdata_b = 1'b0;
  logic cs_n_b, sclk_b, valid_b, ferr_b, busy_b, ovr_b;
  logic [11:0] out_b;

  adc_spi_capture u_dut_a (
    .clk(clk), .rst(rst), .sample_tick(tick_a), .adc_sdata(sdata_a),
    .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .sample_out(out_a),
    .sample_valid(valid_a), .frame_err(ferr_a), .busy(busy_a), .overrun(ovr_a)
  );

  adc_spi_capture #(.CLK_DIV(DIV_B)) u_dut_b (
    .clk(clk), .rst(rst), .sample_tick(tick_b), .adc_sdata(sdata_b),
    .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .sample_out(out_b),
    .sample_valid(valid_b), .frame_err(ferr_b), .busy(busy_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC models: first bit after the first SCLK fall, MSB first
  logic [15:0] word_a = '0, word_b = '0;
  int falls_a = 0, falls_b = 0;

  initial forever begin
    @(negedge cs_n_a or negedge sclk_a);
    if (sclk_a) begin
      falls_a = 0;
      sdata_a = 1'($urandom);
    end else if (!cs_n_a && falls_a < FB) begin
      sdata_a = word_a[15 - falls_a];
      falls_a++;
    end
  end

  initial forever begin
    @(negedge cs_n_b or negedge sclk_b);
    if (sclk_b) begin
      falls_b = 0;
      sdata_b = 1'($urandom);
    end else if (!cs_n_b && falls_b < FB) begin
      sdata_b = word_b[15 - falls_b];
      falls_b++;
    end
  end

  // Observers: valid times (as tick-relative cycle labels), SCLK level runs while CS_n low
  int vt_a[$], vt_b[$];
  logic [11:0] vo_a[$], vo_b[$];
  logic ve_a[$], ve_b[$];
  int runs_a[$], runs_b[$];
  int rise_a = 0, rise_b = 0, cslow_a = 0, cslow_b = 0, run_a = 0, run_b = 0;
  logic pcs_a = 1'b1, pcs_b = 1'b1, psclk_a = 1'b1, psclk_b = 1'b1;

  initial forever begin
    @(negedge clk);
    if (valid_a === 1'b1) begin
      vt_a.push_back(cyc + 1); vo_a.push_back(out_a); ve_a.push_back(ferr_a);
    end
    if (cs_n_a === 1'b0) begin
      cslow_a++;
      if (pcs_a) run_a = 1;
      else if (sclk_a == psclk_a) run_a++;
      else begin
        runs_a.push_back(run_a); run_a = 1;
        if (sclk_a) rise_a++;
      end
    end else if (!pcs_a) runs_a.push_back(run_a);
    pcs_a = (cs_n_a !== 1'b0);
    psclk_a = sclk_a;
  end

  initial forever begin
    @(negedge clk);
    if (valid_b === 1'b1) begin
      vt_b.push_back(cyc + 1); vo_b.push_back(out_b); ve_b.push_back(ferr_b);
    end
    if (cs_n_b === 1'b0) begin
      cslow_b++;
      if (pcs_b) run_b = 1;
      else if (sclk_b == psclk_b) run_b++;
      else begin
        runs_b.push_back(run_b); run_b = 1;
        if (sclk_b) rise_b++;
      end
    end else if (!pcs_b) runs_b.push_back(run_b);
    pcs_b = (cs_n_b !== 1'b0);
    psclk_b = sclk_b;
  end

  task automatic clear_a();
    vt_a.delete(); vo_a.delete(); ve_a.delete(); runs_a.delete();
    rise_a = 0; cslow_a = 0;
  endtask

  task automatic clear_b();
    vt_b.delete(); vo_b.delete(); ve_b.delete(); runs_b.delete();
    rise_b = 0; cslow_b = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // t = index of the clk edge that samples the tick
  task automatic start_a(output int t);
    @(negedge clk);
    tick_a = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    tick_a = 1'b0;
  endtask

  task automatic start_b(output int t);
    @(negedge clk);
    tick_b = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    tick_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs_n_a !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n_a); end
    checks++; if (sclk_a !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", sclk_a); end
    checks++; if (out_a !== 12'h000) begin errors++; $display("FAIL reset_out: got %h want 000", out_a); end
    checks++; if ({valid_a, ferr_a, busy_a, ovr_a} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {valid_a, ferr_a, busy_a, ovr_a});
    end
    checks++; if ({cs_n_b, sclk_b, busy_b} !== 3'b110) begin
      errors++; $display("FAIL reset_b: got %b want 110", {cs_n_b, sclk_b, busy_b});
    end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if ({cs_n_a, busy_a} !== 2'b10) begin
      errors++; $display("FAIL idle_no_tick: got %b want 10", {cs_n_a, busy_a});
    end
  endtask

  task automatic test_frame_a(input logic [15:0] w, input int gap);
    int t, got_t, bad;
    logic [11:0] got_o;
    logic got_e;
    repeat (gap) @(negedge clk);
    clear_a();
    word_a = w;
    start_a(t);
    repeat (LAT_A + 20) @(negedge clk);
    got_t = (vt_a.size() > 0) ? vt_a[0] : -1;
    got_o = (vo_a.size() > 0) ? vo_a[0] : 12'hxxx;
    got_e = (ve_a.size() > 0) ? ve_a[0] : 1'bx;
    bad = 0;
    foreach (runs_a[i]) if (runs_a[i] != DIV_A) bad++;
    checks++; if (vt_a.size() != 1) begin errors++; $display("FAIL valid_count: got %0d want 1", vt_a.size()); end
    checks++; if (got_t != t + LAT_A) begin errors++; $display("FAIL valid_time: got %0d want %0d", got_t, t + LAT_A); end
    checks++; if (got_o !== w[11:0]) begin errors++; $display("FAIL sample_out: got %h want %h", got_o, w[11:0]); end
    checks++; if (got_e !== (|w[15:12])) begin errors++; $display("FAIL frame_err: got %b want %b", got_e, |w[15:12]); end
    checks++; if (rise_a != FB) begin errors++; $display("FAIL sclk_rises: got %0d want %0d", rise_a, FB); end
    checks++; if (cslow_a != LAT_A - 1) begin errors++; $display("FAIL cs_low_len: got %0d want %0d", cslow_a, LAT_A - 1); end
    checks++; if (runs_a.size() != 2 * FB + 1 || bad != 0) begin
      errors++; $display("FAIL sclk_half: runs %0d bad %0d want %0d and 0", runs_a.size(), bad, 2 * FB + 1);
    end
    repeat (30) @(negedge clk);
    checks++; if (out_a !== w[11:0] || ferr_a !== (|w[15:12])) begin
      errors++; $display("FAIL hold: got %h/%b want %h/%b", out_a, ferr_a, w[11:0], |w[15:12]);
    end
    checks++; if (busy_a !== 1'b0 || ovr_a !== 1'b0) begin
      errors++; $display("FAIL post_frame_flags: busy %b ovr %b want 0 0", busy_a, ovr_a);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 0) w[15:12] = 4'h0;
      test_frame_a(w, int'($urandom_range(0, 9)));
    end
  endtask

  task automatic test_overrun();
    int t;
    logic [15:0] w;
    reset_dut();
    clear_a();
    w = {4'h0, 12'($urandom)};
    word_a = w;
    start_a(t);
    while (cyc < t + 49) @(negedge clk);
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b want 0", ovr_a); end
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    repeat (LAT_A) @(negedge clk);
    checks++; if (vt_a.size() != 1) begin errors++; $display("FAIL ovr_valid_count: got %0d want 1", vt_a.size()); end
    checks++; if (vt_a.size() > 0 && vt_a[0] != t + LAT_A) begin
      errors++; $display("FAIL ovr_valid_time: got %0d want %0d", vt_a[0], t + LAT_A);
    end
    checks++; if (out_a !== w[11:0]) begin errors++; $display("FAIL ovr_sample: got %h want %h", out_a, w[11:0]); end
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", ovr_a); end
    repeat (1000) @(negedge clk);
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ovr_a); end
  endtask

  task automatic test_tick_held();
    int t, n;
    reset_dut();
    clear_a();
    word_a = 16'h0123;
    n = int'($urandom_range(5, 40));
    @(negedge clk);
    tick_a = 1'b1;
    t = cyc + 1;
    repeat (n) @(negedge clk);
    tick_a = 1'b0;
    repeat (LAT_A + 10) @(negedge clk);
    checks++; if (vt_a.size() != 1) begin errors++; $display("FAIL held_valid_count: got %0d want 1", vt_a.size()); end
    checks++; if (vt_a.size() > 0 && vt_a[0] != t + LAT_A) begin
      errors++; $display("FAIL held_valid_time: got %0d want %0d", vt_a[0], t + LAT_A);
    end
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL held_ovr: got %b want 1", ovr_a); end
  endtask

  task automatic test_back_to_back();
    int t;
    logic [15:0] w1, w2;
    reset_dut();
    clear_a();
    w1 = {4'h0, 12'($urandom)};
    w2 = {4'h0, 12'($urandom)};
    word_a = w1;
    start_a(t);
    while (cyc < t + SPAN_A - 2) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_busy_hi: got %b want 1", busy_a); end
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_busy_lo: got %b want 0", busy_a); end
    word_a = w2;
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    repeat (LAT_A + 10) @(negedge clk);
    checks++; if (vt_a.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", vt_a.size()); end
    checks++; if (vt_a.size() == 2 && (vt_a[0] != t + LAT_A || vt_a[1] - vt_a[0] != SPAN_A)) begin
      errors++; $display("FAIL b2b_times: got %0d,%0d want %0d,%0d", vt_a[0], vt_a[1], t + LAT_A, t + LAT_A + SPAN_A);
    end
    checks++; if (vo_a.size() == 2 && (vo_a[0] !== w1[11:0] || vo_a[1] !== w2[11:0])) begin
      errors++; $display("FAIL b2b_data: got %h,%h want %h,%h", vo_a[0], vo_a[1], w1[11:0], w2[11:0]);
    end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b want 0", ovr_a); end
  endtask

  task automatic test_early_tick();
    int t;
    reset_dut();
    clear_a();
    word_a = 16'h0777;
    start_a(t);
    while (cyc < t + SPAN_A - 2) @(negedge clk);
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    repeat (LAT_A + 10) @(negedge clk);
    checks++; if (vt_a.size() != 1) begin errors++; $display("FAIL early_count: got %0d want 1", vt_a.size()); end
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL early_ovr: got %b want 1", ovr_a); end
  endtask

  task automatic test_reset_midframe();
    int t;
    reset_dut();
    test_frame_a(16'h0ABC, 1);
    clear_a();
    word_a = 16'h0555;
    start_a(t);
    while (cyc < t + 59) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({cs_n_a, sclk_a} !== 2'b11) begin
      errors++; $display("FAIL midrst_pins: got %b want 11", {cs_n_a, sclk_a});
    end
    checks++; if (out_a !== 12'h000 || busy_a !== 1'b0) begin
      errors++; $display("FAIL midrst_state: out %h busy %b want 000 0", out_a, busy_a);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (LAT_A + 10) @(negedge clk);
    checks++; if (vt_a.size() != 0 || out_a !== 12'h000) begin
      errors++; $display("FAIL midrst_no_valid: count %0d out %h want 0 000", vt_a.size(), out_a);
    end
    test_frame_a({4'h0, 12'($urandom)}, 2);
  endtask

  task automatic test_clkdiv2();
    int t, bad;
    clear_b();
    word_b = 16'h0001;
    start_b(t);
    repeat (LAT_B + 15) @(negedge clk);
    bad = 0;
    foreach (runs_b[i]) if (runs_b[i] != DIV_B) bad++;
    checks++; if (vt_b.size() != 1) begin errors++; $display("FAIL div2_count: got %0d want 1", vt_b.size()); end
    checks++; if (vt_b.size() > 0 && vt_b[0] != t + LAT_B) begin
      errors++; $display("FAIL div2_time: got %0d want %0d", vt_b[0], t + LAT_B);
    end
    checks++; if (vo_b.size() > 0 && (vo_b[0] !== 12'h001 || ve_b[0] !== 1'b0)) begin
      errors++; $display("FAIL div2_data: got %h/%b want 001/0", vo_b[0], ve_b[0]);
    end
    checks++; if (rise_b != FB || cslow_b != LAT_B - 1) begin
      errors++; $display("FAIL div2_frame: rises %0d cs_low %0d want %0d %0d", rise_b, cslow_b, FB, LAT_B - 1);
    end
    checks++; if (runs_b.size() != 2 * FB + 1 || bad != 0) begin
      errors++; $display("FAIL div2_half: runs %0d bad %0d want %0d and 0", runs_b.size(), bad, 2 * FB + 1);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a(16'h0A5C, 2);
    test_frame_a(16'h8FFF, 5);
    test_random();
    test_overrun();
    test_tick_held();
    test_back_to_back();
    test_early_tick();
    test_reset_midframe();
    test_clkdiv2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- Serial capture stage directly downstream of the ADC clock divider.
- Once per sample-rate strobe, it runs one SPI-style read frame on an AD7476-class 12-bit ADC (CS_n, SCLK, SDATA).
- It delivers each sample as a parallel word with a one-cycle valid pulse to the equalizer datapath.
- It keeps all logic on the system clock; SCLK is generated from clock-enable counting, never as a derived clock.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period (legal range 2..255).
- FRAME_BITS, 16, SCLK periods per conversion frame.
- DATA_BITS, 12, sample width; the last DATA_BITS bits of the frame.
- LEAD_BITS, 4, leading bits that must read 0 (FRAME_BITS = LEAD_BITS + DATA_BITS).

Ports:
- clk, input, 1: system clock (100 MHz).
- rst, input, 1: asynchronous active-low reset (0 = reset).
- sample_tick, input, 1: one-clk-wide start strobe from the divider stage.
- adc_sdata, input, 1: serial data from the ADC; changes after SCLK falling edge.
- adc_cs_n, output, 1: ADC chip select, active low.
- adc_sclk, output, 1: serial clock; idles high.
- sample_out, output, DATA_BITS: last captured sample, unsigned, MSB first on the wire.
- sample_valid, output, 1: one-cycle pulse when sample_out is updated.
- frame_err, output, 1: qualified by sample_valid; 1 if any leading bit read non-zero.
- busy, output, 1: high while a frame or the quiet time is in progress.
- overrun, output, 1: sticky; set when sample_tick arrives while busy.

Behaviour:

Reset values (rst low, asynchronous):
- adc_cs_n=1, adc_sclk=1.
- sample_out=0, sample_valid=0, frame_err=0, busy=0, overrun=0.
- FSM goes to IDLE; all counters and the shift register go to 0.
- Reset mid-frame aborts immediately: CS_n and SCLK return high and no sample_valid is issued.

FSM states and transitions:
- IDLE: busy=0. On sample_tick=1 at edge T: go to SETUP, with cs_n=0 and busy=1 from T+1.
- SETUP: hold SCLK high for CLK_DIV cycles, then go to SHIFT.
- SHIFT: FRAME_BITS periods; each period is SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the clk edge that drives SCLK 0->1, shift adc_sdata into the LSB of a FRAME_BITS shift register.
  - adc_sdata is sampled raw; the ADC output is stable for CLK_DIV cycles before the rising edge, so no synchronizer is used.
  - After the final high half-period, go to DONE.
- DONE (one cycle):
  - cs_n=1.
  - sample_out = shift[DATA_BITS-1:0].
  - frame_err = |shift[FRAME_BITS-1:DATA_BITS].
  - sample_valid=1 for exactly this cycle.
  - Go to QUIET.
- QUIET: cs_n=1, busy=1 for CLK_DIV-1 cycles, then go to IDLE.

Timing (defaults: CLK_DIV=4, FRAME_BITS=16):
- cs_n is low from T+1 through T+132 (CLK_DIV*(1+2*FRAME_BITS) = 132 cycles).
- sample_valid and cs_n=1 at T+133.
- busy deasserts at T+137; a tick sampled at edge T+137 starts the next frame.
- Exact SCLK edge count per frame: FRAME_BITS falling and FRAME_BITS rising edges.

Boundary conditions:
- sample_tick while busy=1: ignored (no restart, no queue); overrun set to 1 and held until reset.
- sample_tick in the same cycle busy returns low (IDLE): accepted normally; overrun not set.
- sample_tick held high for many cycles: the first cycle starts a frame; later cycles while busy set overrun.
- sample_out holds its value between valid pulses.
- frame_err is updated only in DONE.
- Counters never wrap mid-frame; the half-period counter reloads to 0 each half-period.
- All outputs are registered.

Test Plan:
- Reset, then one sample_tick; ADC model returns 0x0A5C (leading 0000) -> sample_valid pulse at T+133, sample_out=0xA5C, frame_err=0, exactly 16 SCLK rising edges while cs_n low, cs_n low for 132 cycles.
- ADC model returns 0x8FFF -> sample_out=0xFFF, frame_err=1 on the valid cycle.
- Ticks at T and T+50 -> single frame, one valid pulse, overrun=1 and still 1 after 1000 idle cycles.
- Ticks at T and exactly T+137 -> two back-to-back frames, two valid pulses 137 cycles apart, overrun=0.
- Assert rst low at T+60 for 3 cycles, mid-frame -> cs_n=1 and sclk=1 immediately (asynchronous), no valid pulse, sample_out=0. A new tick afterwards completes a normal frame.
- CLK_DIV=2, ADC returns 0x0001 -> sample_out=0x001, valid at T+67, SCLK half-period of 2 clks throughout.
